// File: rtl/lsu_ctrl.sv
// Load/store sequencer: classifies a decoded access, runs one valid/ack bus cycle, returns aligned/extended load data.
// Latency: 3 cycles for an ack in the first bus cycle, +1 per wait state; faults complete in 2 cycles.
// Backpressure: stall_o holds the core while a request is being accepted or is on the bus; an optional timeout aborts a hung access.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_width_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic        dmem_valid_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_sel_o,
    output logic [31:0] dmem_data_o,
    input  logic [31:0] dmem_data_i,
    input  logic        dmem_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic          we_q;
    logic [2:0]    width_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   data_q;
    logic [1:0]    cause_q;
    logic [CW-1:0] cnt_q;

    logic        illegal, misal, to_hit;
    logic        busy, done;
    logic [1:0]  off;
    logic [3:0]  sel;
    logic [31:0] wdat, shifted, ext;

    always_comb begin
        illegal = req_we_i ? (req_width_i > 3'b010)
                           : !(req_width_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal   = ((req_width_i[1:0] == 2'b01) && req_addr_i[0]) ||
                  ((req_width_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        to_hit  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            width_q <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        width_q <= req_width_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        data_q  <= 32'h0;
                        cnt_q   <= '0;
                        cause_q <= illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
                    end
                end
                BUSY: begin
                    // ack wins over a timeout landing in the same cycle
                    if (dmem_ack_i)  data_q  <= dmem_data_i;
                    else if (to_hit) cause_q <= 2'b10;
                    else             cnt_q   <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = (illegal || misal) ? DONE : BUSY;
            BUSY:    if (dmem_ack_i || to_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == BUSY);
        done    = (state_q == DONE);
        off     = addr_q[1:0];
        case (width_q[1:0])
            2'b00:   sel = 4'b0001 << off;
            2'b01:   sel = 4'b0011 << off;
            default: sel = 4'b1111;
        endcase
        case (width_q[1:0])
            2'b00:   wdat = {4{wdata_q[7:0]}};
            2'b01:   wdat = {2{wdata_q[15:0]}};
            default: wdat = wdata_q;
        endcase
        shifted = data_q >> {off, 3'b000};
        case (width_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign stall_o      = ((state_q == IDLE) && req_valid_i) || busy;
    assign done_o       = done;
    assign err_o        = done && (cause_q != 2'b00);
    assign err_cause_o  = done ? cause_q : 2'b00;
    assign rdata_o      = (done && !we_q && (cause_q == 2'b00)) ? ext : 32'h0;
    assign dmem_valid_o = busy;
    assign dmem_we_o    = busy && we_q;
    assign dmem_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem_sel_o   = busy ? sel : 4'b0000;
    assign dmem_data_o  = busy ? wdat : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus randomized accesses against a byte-level reference model.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_we_i;
    logic [2:0]  req_width_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic [1:0]  err_cause_o;
    logic        dmem_valid_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_data_o, dmem_data_i;
    logic [3:0]  dmem_sel_o;
    logic        dmem_ack_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_width_i(req_width_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .err_o(err_o), .err_cause_o(err_cause_o),
        .dmem_valid_o(dmem_valid_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_sel_o(dmem_sel_o), .dmem_data_o(dmem_data_o),
        .dmem_data_i(dmem_data_i), .dmem_ack_i(dmem_ack_i)
    );

    function automatic int nbytes(input logic [2:0] w);
        if (w[1:0] == 2'b00) return 1;
        if (w[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] model_cause(input logic we, input logic [2:0] w, input logic [31:0] a);
        bit legal;
        legal = we ? (w <= 3'd2) : (w == 3'd0 || w == 3'd1 || w == 3'd2 || w == 3'd4 || w == 3'd5);
        if (!legal) return 2'b11;
        if ((int'(a[1:0]) % nbytes(w)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_sel(input logic [2:0] w, input logic [31:0] a);
        logic [3:0] s;
        int o;
        s = 4'b0000;
        o = (nbytes(w) == 4) ? 0 : int'(a[1:0]);
        for (int i = 0; i < nbytes(w); i++) s[o + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] w, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(w)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] bus);
        logic [63:0] v;
        int nb, o;
        nb = nbytes(w);
        o  = int'(a[1:0]);
        v  = 64'h0;
        for (int i = 0; i < nb; i++) v = v | (64'(bus[8*(o + i) +: 8]) << (8*i));
        if (!w[2] && nb < 4 && v[8*nb - 1]) v = v - (64'd1 << (8*nb));
        return v[31:0];
    endfunction

    task automatic run_txn(input logic we, input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] bus_rd, input int waits,
                           output logic [3:0] s_sel, output logic [31:0] s_dat,
                           output logic [31:0] r, output int nbusy);
        logic [1:0]  ec;
        logic [31:0] er;
        int exp_busy, n;
        bit fin;
        ec = model_cause(we, w, a);
        if (ec != 2'b00)   exp_busy = 0;
        else if (waits >= TO) begin ec = 2'b10; exp_busy = TO; end
        else               exp_busy = waits + 1;
        er = (we || ec != 2'b00) ? 32'h0 : model_load(w, a, bus_rd);
        s_sel = 4'h0; s_dat = 32'h0; r = 32'h0; nbusy = 0; n = 0; fin = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_width_i = w; req_addr_i = a; req_wdata_i = wd;
        dmem_ack_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1 || dmem_valid_o !== 1'b0)
            $display("FAIL accept_cycle stall=%b valid=%b required stall=1 valid=0", stall_o, dmem_valid_o);
        if (stall_o !== 1'b1 || dmem_valid_o !== 1'b0) failures++;
        while (!fin && n < 20) begin
            @(negedge clk);
            n++;
            if (done_o === 1'b1) begin
                fin = 1;
                r = rdata_o;
                checks++;
                if (n != exp_busy + 1) begin failures++; $display("FAIL done_cycle got=%0d required=%0d", n, exp_busy + 1); end
                checks++;
                if (nbusy != exp_busy) begin failures++; $display("FAIL busy_cycles got=%0d required=%0d", nbusy, exp_busy); end
                checks++;
                if (err_o !== (ec != 2'b00) || err_cause_o !== ec) begin
                    failures++; $display("FAIL err got=%b/%b required=%b/%b", err_o, err_cause_o, ec != 2'b00, ec);
                end
                checks++;
                if (rdata_o !== er) begin failures++; $display("FAIL rdata got=%h required=%h", rdata_o, er); end
                checks++;
                if (stall_o !== 1'b0 || dmem_valid_o !== 1'b0) begin
                    failures++; $display("FAIL done_state stall=%b valid=%b required 0/0", stall_o, dmem_valid_o);
                end
                req_valid_i = 1'b0; dmem_ack_i = 1'b0;
            end else begin
                nbusy++;
                checks++;
                if ({dmem_valid_o, stall_o, dmem_we_o} !== {2'b11, we}) begin
                    failures++; $display("FAIL busy_ctrl valid/stall/we got=%b%b%b required=11%b", dmem_valid_o, stall_o, dmem_we_o, we);
                end
                checks++;
                if (dmem_addr_o !== {a[31:2], 2'b00} || dmem_sel_o !== model_sel(w, a)) begin
                    failures++; $display("FAIL busy_addr_sel got=%h/%b required=%h/%b", dmem_addr_o, dmem_sel_o, {a[31:2], 2'b00}, model_sel(w, a));
                end
                if (we) begin
                    checks++;
                    if (dmem_data_o !== model_wdata(w, wd)) begin
                        failures++; $display("FAIL busy_wdata got=%h required=%h", dmem_data_o, model_wdata(w, wd));
                    end
                end
                checks++;
                if ({rdata_o, err_o, err_cause_o} !== 35'h0) begin
                    failures++; $display("FAIL busy_result_zero got rdata=%h err=%b cause=%b required 0", rdata_o, err_o, err_cause_o);
                end
                s_sel = dmem_sel_o; s_dat = dmem_data_o;
                if (nbusy == waits + 1) begin dmem_ack_i = 1'b1; dmem_data_i = bus_rd; end
                else begin dmem_ack_i = 1'b0; dmem_data_i = $urandom; end
            end
        end
        if (!fin) begin
            checks++; failures++;
            $display("FAIL done_wait no done_o within 20 cycles");
            req_valid_i = 1'b0; dmem_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_width_i = 3'b000;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; dmem_data_i = 32'h0; dmem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall_o, done_o, rdata_o, err_o, err_cause_o} !== 37'h0) begin
            failures++; $display("FAIL reset_core stall=%b done=%b rdata=%h err=%b cause=%b required all 0", stall_o, done_o, rdata_o, err_o, err_cause_o);
        end
        checks++;
        if ({dmem_valid_o, dmem_we_o, dmem_addr_o, dmem_sel_o, dmem_data_o} !== 70'h0) begin
            failures++; $display("FAIL reset_bus valid=%b we=%b addr=%h sel=%b data=%h required all 0", dmem_valid_o, dmem_we_o, dmem_addr_o, dmem_sel_o, dmem_data_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_loads();
        logic [3:0] s; logic [31:0] d, r; int nb;
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, s, d, r, nb);
        checks++;
        if (r !== 32'hDEADBEEF || s !== 4'b1111 || nb != 1) begin
            failures++; $display("FAIL lw_basic rdata=%h sel=%b busy=%0d required DEADBEEF/1111/1", r, s, nb);
        end
        run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80123456, 1, s, d, r, nb);
        checks++;
        if (r !== 32'hFFFFFF80 || s !== 4'b1000) begin
            failures++; $display("FAIL lb_sign rdata=%h sel=%b required FFFFFF80/1000", r, s);
        end
        run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80123456, 0, s, d, r, nb);
        checks++;
        if (r !== 32'h00000080 || s !== 4'b1000) begin
            failures++; $display("FAIL lbu_zero rdata=%h sel=%b required 00000080/1000", r, s);
        end
    endtask

    task automatic test_store_wait();
        logic [3:0] s; logic [31:0] d, r; int nb;
        run_txn(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h12345678, 3, s, d, r, nb);
        checks++;
        if (d !== 32'hABCDABCD || s !== 4'b1100 || nb != 4 || r !== 32'h0) begin
            failures++; $display("FAIL sh_wait data=%h sel=%b busy=%0d rdata=%h required ABCDABCD/1100/4/0", d, s, nb, r);
        end
    endtask

    task automatic test_faults();
        logic [3:0] s; logic [31:0] d, r; int nb;
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0, s, d, r, nb);
        checks++;
        if (nb != 0 || r !== 32'h0) begin failures++; $display("FAIL lw_misaligned busy=%0d rdata=%h required 0/0", nb, r); end
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'hFFFFFFFF, 0, s, d, r, nb);
        checks++;
        if (nb != 0) begin failures++; $display("FAIL illegal_width busy=%0d required 0", nb); end
    endtask

    task automatic test_timeout();
        logic [3:0] s; logic [31:0] d, r; int nb;
        run_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, 100, s, d, r, nb);
        checks++;
        if (nb != TO) begin failures++; $display("FAIL timeout_len busy=%0d required=%0d", nb, TO); end
    endtask

    task automatic test_reset_mid_busy();
        logic [3:0] s; logic [31:0] d, r; int nb;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_width_i = 3'b010; req_addr_i = 32'h400; dmem_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_valid_o !== 1'b1) begin failures++; $display("FAIL rst_pre_busy valid=%b required 1", dmem_valid_o); end
        #2;
        rst_i = 1'b1; req_valid_i = 1'b0;
        #1;
        checks++;
        if (dmem_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL rst_mid_busy valid=%b stall=%b required 0/0", dmem_valid_o, stall_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        dmem_ack_i = 1'b1; dmem_data_i = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || dmem_valid_o !== 1'b0 || rdata_o !== 32'h0) begin
            failures++; $display("FAIL ack_in_idle done=%b valid=%b rdata=%h required 0/0/0", done_o, dmem_valid_o, rdata_o);
        end
        dmem_ack_i = 1'b0;
        run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADC0DE, 1, s, d, r, nb);
        checks++;
        if (r !== 32'h0BADC0DE) begin failures++; $display("FAIL post_reset_lw rdata=%h required 0BADC0DE", r); end
    endtask

    task automatic test_random();
        logic [3:0] s; logic [31:0] d, r, a; int nb;
        logic we; logic [2:0] w;
        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            w  = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_txn(we, w, a, $urandom, $urandom, $urandom_range(0, 5), s, d, r, nb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_wait();
        test_faults();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the decode/execute stage and the data-memory bus of the atom core. Accepts one decoded load or store (address from the ALU, width from func3), checks alignment, drives a valid/ack bus transaction with byte-lane selects, and returns an aligned, sign- or zero-extended load result. Holds the core in stall until the access completes or faults.

## Interface
- `TIMEOUT`, default 0: number of BUSY cycles without ack before the access is aborted; 0 disables the timeout.
- `clk_i`  in  1  clock; everything is sampled on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  a decoded load/store is in execute; must be held until `done_o`.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_width_i`  in  3  func3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use only 000, 001 and 010.
- `req_addr_i`  in  32  effective byte address.
- `req_wdata_i`  in  32  store data, right-aligned.
- `stall_o`  out  1  core must not advance.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  load result, valid while `done_o`=1; 0 for stores and faults.
- `err_o`  out  1  with `done_o`: the access faulted.
- `err_cause_o`  out  2  01 misaligned, 10 timeout, 11 illegal width; 00 otherwise.
- `dmem_valid_o`  out  1  bus request.
- `dmem_we_o`  out  1  bus write.
- `dmem_addr_o`  out  32  word address, `{req_addr[31:2],2'b00}`.
- `dmem_sel_o`  out  4  byte-lane enables.
- `dmem_data_o`  out  32  lane-replicated write data.
- `dmem_data_i`  in  32  read data, valid with ack.
- `dmem_ack_i`  in  1  transaction complete.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE and drives every output and internal register to 0.
- IDLE with `req_valid_i`=1: latch we, width, addr and wdata, then classify the access:
  - Illegal width (load 011/110/111, store not 000/001/010): go to DONE with cause 11.
  - Misaligned (H/HU with addr[0]=1, W with addr[1:0]≠0): go to DONE with cause 01. No bus cycle is issued.
  - Otherwise go to BUSY.
- BUSY:
  - `dmem_valid_o`=1, bus outputs come from the latched registers and are stable for the whole state.
  - On `dmem_ack_i` capture `dmem_data_i` and go to DONE.
  - A timeout counter runs when TIMEOUT>0. It is cleared on entry to BUSY. If it reaches TIMEOUT without ack, drop valid and go to DONE with cause 10.
- DONE: `done_o`=1 for one cycle, `err_o` = (cause≠0), then return to IDLE. `req_valid_i` is ignored in DONE; the next request is accepted from IDLE.
- Byte-lane selects (`off` = addr[1:0]):
  - B/BU: `sel = 0001<<off`.
  - H/HU: `sel = 0011<<off`.
  - W: `sel = 1111`.
- Store data: SB drives `{4{wdata[7:0]}}`, SH drives `{2{wdata[15:0]}}`, SW drives `wdata`.
- Load extraction: `d = captured >> (8*off)`.
  - B: `{{24{d[7]}},d[7:0]}`; BU: `{24'b0,d[7:0]}`.
  - H: `{{16{d[15]}},d[15:0]}`; HU: `{16'b0,d[15:0]}`.
  - W: `d`.
- `stall_o` = (IDLE & `req_valid_i`) | BUSY. It is 0 in DONE, which is the cycle in which the core retires the instruction.
- `dmem_ack_i` is ignored outside BUSY.
- Reset asserted mid-BUSY: the FSM goes to IDLE immediately (asynchronously) and valid drops. The bus slave must tolerate the abandoned transaction.

## Timing
- Aligned access with ack in the first BUSY cycle:
  - Cycle 0: IDLE, accept.
  - Cycle 1: BUSY, valid=1, ack=1.
  - Cycle 2: DONE.
  - `stall_o` is high in cycles 0 and 1; total latency is 3 cycles.
- Each wait state (ack low while in BUSY) adds one BUSY cycle.
- Faults (misaligned or illegal width): IDLE → DONE, 2 cycles, `dmem_valid_o` never asserted.
- Timeout: exactly TIMEOUT BUSY cycles, then DONE.
- Bus outputs are registered or state-decoded and never depend combinationally on `dmem_ack_i`.
- `rdata_o`, `err_o` and `err_cause_o` are valid only in DONE and are 0 in every other state.

## Test plan
- LW at addr 0x100; slave acks in the first BUSY cycle with 0xDEADBEEF → `dmem_addr_o`=0x100, `sel`=1111, `rdata_o`=0xDEADBEEF; `stall_o` high for 2 cycles, `done_o` high for 1 cycle.
- LB at 0x203 and LBU at 0x203, read data 0x80123456 → LB gives `rdata_o`=0xFFFFFF80, LBU gives 0x00000080; `sel`=1000 in both.
- SH at 0x302 with `req_wdata_i`=0x0000ABCD, ack after 3 wait cycles → `dmem_we_o`=1, `sel`=1100, `dmem_data_o`=0xABCDABCD, held stable for 4 BUSY cycles; then `done_o`=1, `rdata_o`=0.
- LW at 0x102 → `dmem_valid_o` never asserted; DONE on cycle 1 with `err_o`=1, `err_cause_o`=01. Repeat with load width 011 → `err_cause_o`=11.
- TIMEOUT=4, no ack → `valid` high for exactly 4 cycles, then `done_o`=1, `err_cause_o`=10.
- `rst_i` pulsed during BUSY → `dmem_valid_o` and `stall_o` drop in the same cycle; a following LW completes normally; an ack arriving while IDLE has no effect.
